// File: rtl/adpll_pkg.sv
// Shared ADPLL definitions: lock-sequencer state encoding and the adpll_mode codes
// understood by adpll_ctr.
package adpll_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PWRUP  = 3'd1,
    ST_PVT    = 3'd2,
    ST_ACQ    = 3'd3,
    ST_TRK    = 3'd4,
    ST_LOCKED = 3'd5
  } seq_state_t;

  localparam logic [1:0] MODE_OFF = 2'd0;
  localparam logic [1:0] MODE_PVT = 2'd1;
  localparam logic [1:0] MODE_ACQ = 2'd2;
  localparam logic [1:0] MODE_TRK = 2'd3;

  function automatic logic [1:0] mode_of(input seq_state_t s);
    logic [1:0] m;
    m = MODE_OFF;
    case (s)
      ST_PVT:            m = MODE_PVT;
      ST_ACQ:            m = MODE_ACQ;
      ST_TRK, ST_LOCKED: m = MODE_TRK;
      default:           m = MODE_OFF;
    endcase
    return m;
  endfunction

  // The injection path comes up with acquisition and stays up while tracking.
  function automatic logic inj_pd_of(input seq_state_t s);
    return !((s == ST_ACQ) || (s == ST_TRK) || (s == ST_LOCKED));
  endfunction

endpackage

// File: rtl/adpll_lock_det.sv
// Lock qualifier: saturating |phase_err|, threshold compare and consecutive good/bad
// sample counters producing single-cycle lock_hit / unlock_hit indications.
module adpll_lock_det
  import adpll_pkg::*;
#(
  parameter int PHE_W      = 20,
  parameter int LOCK_THR   = 64,
  parameter int LOCK_CNT   = 16,
  parameter int UNLOCK_CNT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic signed [PHE_W-1:0] phase_err,
  output logic                    lock_hit,
  output logic                    unlock_hit
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(UNLOCK_CNT + 1);
  localparam logic [GW-1:0] GOOD_MAX  = GW'(LOCK_CNT);
  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_CNT - 1);
  localparam logic [BW-1:0] BAD_MAX   = BW'(UNLOCK_CNT);
  localparam logic [BW-1:0] BAD_LAST  = BW'(UNLOCK_CNT - 1);
  localparam logic [PHE_W-1:0] THR      = PHE_W'(LOCK_THR);
  localparam logic [PHE_W-1:0] MOST_NEG = {1'b1, {(PHE_W-1){1'b0}}};
  localparam logic [PHE_W-1:0] MAG_MAX  = {1'b0, {(PHE_W-1){1'b1}}};

  logic [PHE_W-1:0] mag;
  logic             good;
  logic [GW-1:0]    good_cnt;
  logic [BW-1:0]    bad_cnt;

  // Negating the most negative code would wrap back to itself, so pin it to full scale.
  always_comb begin
    mag = $unsigned(phase_err);
    if ($unsigned(phase_err) == MOST_NEG) begin
      mag = MAG_MAX;
    end else if (phase_err[PHE_W-1]) begin
      mag = $unsigned(-phase_err);
    end
  end

  assign good = (mag < THR);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      good_cnt <= '0;
      bad_cnt  <= '0;
    end else if (good) begin
      bad_cnt <= '0;
      if (good_cnt != GOOD_MAX) good_cnt <= good_cnt + GW'(1);
    end else begin
      good_cnt <= '0;
      if (bad_cnt != BAD_MAX) bad_cnt <= bad_cnt + BW'(1);
    end
  end

  assign lock_hit   = !clear && good  && (good_cnt == GOOD_LAST);
  assign unlock_hit = !clear && !good && (bad_cnt == BAD_LAST);

endmodule

// File: rtl/adpll_lock_seq.sv
// ADPLL power-up and lock sequencer: wakes DCO/TDC, walks adpll_ctr through
// PVT -> ACQ -> TRK with fixed dwells, qualifies lock and restarts on FCW retune.
module adpll_lock_seq
  import adpll_pkg::*;
#(
  parameter int PD_SETTLE_CYC = 32,
  parameter int PVT_CYC       = 256,
  parameter int ACQ_CYC       = 256,
  parameter int PHE_W         = 20,
  parameter int LOCK_THR      = 64,
  parameter int LOCK_CNT      = 16,
  parameter int UNLOCK_CNT    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    fcw_load,
  input  logic signed [PHE_W-1:0] phase_err,
  output logic                    dco_pd,
  output logic                    tdc_pd,
  output logic                    tdc_pd_inj,
  output logic [1:0]              adpll_mode,
  output logic                    lock,
  output logic [7:0]              relock_cnt,
  output logic [2:0]              state
);

  localparam int DW = $clog2(PD_SETTLE_CYC + PVT_CYC + ACQ_CYC);
  localparam logic [DW-1:0] PD_LAST  = DW'(PD_SETTLE_CYC - 1);
  localparam logic [DW-1:0] PVT_LAST = DW'(PVT_CYC - 1);
  localparam logic [DW-1:0] ACQ_LAST = DW'(ACQ_CYC - 1);

  seq_state_t    cur_st;
  seq_state_t    nxt_st;
  logic [DW-1:0] dwell;
  logic          in_loop;
  logic          restart;
  logic          det_clear;
  logic          lock_hit;
  logic          unlock_hit;

  assign in_loop = (cur_st == ST_PVT) || (cur_st == ST_ACQ) ||
                   (cur_st == ST_TRK) || (cur_st == ST_LOCKED);

  // Priority order: en low, then FCW retune, then lock qualification, then dwell expiry.
  always_comb begin
    nxt_st  = cur_st;
    restart = 1'b0;
    if (!en) begin
      nxt_st = ST_IDLE;
    end else if (fcw_load && in_loop) begin
      nxt_st  = ST_PVT;
      restart = 1'b1;
    end else begin
      case (cur_st)
        ST_IDLE:   nxt_st = ST_PWRUP;
        ST_PWRUP:  if (dwell == PD_LAST)  nxt_st = ST_PVT;
        ST_PVT:    if (dwell == PVT_LAST) nxt_st = ST_ACQ;
        ST_ACQ:    if (dwell == ACQ_LAST) nxt_st = ST_TRK;
        ST_TRK:    if (lock_hit)          nxt_st = ST_LOCKED;
        ST_LOCKED: if (unlock_hit)        nxt_st = ST_TRK;
        default:   nxt_st = ST_IDLE;
      endcase
    end
  end

  // Sample counters only run while the loop is tracking and drop instantly on any exit.
  assign det_clear = !((cur_st == ST_TRK) || (cur_st == ST_LOCKED)) || !en || fcw_load;

  adpll_lock_det #(
    .PHE_W      (PHE_W),
    .LOCK_THR   (LOCK_THR),
    .LOCK_CNT   (LOCK_CNT),
    .UNLOCK_CNT (UNLOCK_CNT)
  ) u_lock_det (
    .clk        (clk),
    .rst        (rst),
    .clear      (det_clear),
    .phase_err  (phase_err),
    .lock_hit   (lock_hit),
    .unlock_hit (unlock_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_st     <= ST_IDLE;
      dwell      <= '0;
      dco_pd     <= 1'b1;
      tdc_pd     <= 1'b1;
      tdc_pd_inj <= 1'b1;
      adpll_mode <= MODE_OFF;
      lock       <= 1'b0;
      relock_cnt <= 8'd0;
    end else begin
      cur_st     <= nxt_st;
      dwell      <= ((nxt_st != cur_st) || restart) ? '0 : dwell + DW'(1);
      dco_pd     <= (nxt_st == ST_IDLE);
      tdc_pd     <= (nxt_st == ST_IDLE);
      tdc_pd_inj <= inj_pd_of(nxt_st);
      adpll_mode <= mode_of(nxt_st);
      lock       <= (nxt_st == ST_LOCKED);
      if ((cur_st == ST_LOCKED) && (nxt_st == ST_TRK) && (relock_cnt != 8'hFF)) begin
        relock_cnt <= relock_cnt + 8'd1;
      end
    end
  end

  assign state = cur_st;

endmodule
